// File: rtl/relu_remask_pkg.sv
// Shared types and helpers for the relu_remask re-sharing stage.
// The optional input clamp is enabled by defining RELU_REMASK_CLAMP_EN.
package relu_pkg;

  // Default element width, and the offset-binary zero point for that width.
  localparam int RELU_N = 8;
  localparam logic [RELU_N-1:0] MAX_INT = RELU_N'(2 ** (RELU_N - 1));

  typedef enum logic [1:0] {
    IDLE_RST = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } remask_state_t;

  // Offset-binary to two's complement for an n-bit value: subtracting
  // 2^(n-1) modulo 2^n is the same as inverting bit n-1.
  function automatic logic [31:0] offset_to_tc(input logic [31:0] y, input int unsigned n);
    return y ^ (32'd1 << (n - 1));
  endfunction

endpackage

// File: rtl/relu_remask_if.sv
// Element stream interface: input pair (r2, y) in, remasked share out.
interface relu_remask_if #(
  parameter int N = 8
) ();

  logic [N-1:0] g_input;
  logic [N-1:0] e_input;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] o;
  logic         o_valid;
  logic         o_ready;
  logic         o_last;

  modport master (
    output g_input, e_input, in_valid, o_ready,
    input  in_ready, o, o_valid, o_last
  );

  modport slave (
    input  g_input, e_input, in_valid, o_ready,
    output in_ready, o, o_valid, o_last
  );

endinterface

// File: rtl/relu_remask_fifo2.sv
// Two-entry synchronous FIFO with first-word-fall-through read port.
module sync_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];

  // Storage write.
  // NOTE: storage has no reset; stale contents are never visible because
  // the consumer only uses o_dout while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy tracking.
  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/relu_remask.sv
// relu_remask: converts offset-binary ReLU results to two's complement,
// subtracts the garbler mask r2, buffers two results and marks frames.
// Optional feature macro: RELU_REMASK_CLAMP_EN (clamp MSB=0 inputs to zero,
// adds sticky clamp_seen output).
module relu_remask
  import relu_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic rst,
  relu_remask_if.slave bus,
  output logic frame_done
`ifdef RELU_REMASK_CLAMP_EN
  ,
  output logic clamp_seen
`endif
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [N-1:0] L_MAX_INT = N'(1) << (N - 1);

  remask_state_t r_state;
  remask_state_t w_state_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_last_pend;
  logic          r_frame_done;

  logic          w_full;
  logic          w_empty;
  logic          w_in_ready;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_is_last;
  logic          w_push_last;
  logic          w_pop_last;
  logic [1:0]    w_last_pend_next;
  logic [N-1:0]  w_y;
  logic [N-1:0]  w_v;
  logic [N-1:0]  w_o_calc;
  logic [N-1:0]  w_dout_o;
  logic          w_dout_last;

`ifdef RELU_REMASK_CLAMP_EN
  logic w_clamp;
  logic r_clamp_seen;
  // A negative (MSB=0) ReLU result is invalid; treat it as zero.
  assign w_clamp    = !bus.e_input[N-1];
  assign w_y        = w_clamp ? L_MAX_INT : bus.e_input;
  assign clamp_seen = r_clamp_seen;
`else
  assign w_y = bus.e_input;
`endif

  assign w_v      = N'(offset_to_tc(32'(w_y), N));
  assign w_o_calc = w_v - bus.g_input;

  assign w_in_ready  = (r_state != IDLE_RST) && !w_full;
  assign w_in_xfer   = bus.in_valid && w_in_ready;
  assign w_out_xfer  = !w_empty && bus.o_ready;
  assign w_is_last   = (r_cnt == CW'(LEN - 1));
  assign w_push_last = w_in_xfer && w_is_last;
  assign w_pop_last  = w_out_xfer && w_dout_last;
  // Last-tagged entries still in the buffer after this edge.
  assign w_last_pend_next = r_last_pend + {1'b0, w_push_last} - {1'b0, w_pop_last};

  sync_fifo2 #(.W(N + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_in_xfer),
    .i_pop   (w_out_xfer),
    .i_din   ({w_o_calc, w_is_last}),
    .o_dout  ({w_dout_o, w_dout_last}),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.in_ready = w_in_ready;
  assign bus.o_valid  = !w_empty;
  assign bus.o        = w_empty ? '0 : w_dout_o;
  assign bus.o_last   = !w_empty && w_dout_last;
  assign frame_done   = r_frame_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE_RST;
    else     r_state <= w_state_next;
  end

  // Next-state logic: stay in DRAIN while any last-tagged entry is buffered.
  // NOTE: default assignment first so no path leaves w_state_next unassigned
  // (which would infer a latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE_RST: w_state_next = RUN;
      RUN:      if (w_push_last) w_state_next = DRAIN;
      DRAIN:    if (w_last_pend_next == 2'd0) w_state_next = RUN;
      default:  w_state_next = IDLE_RST;
    endcase
  end

  // Element counter, wrapping after the last element of a frame.
  always_ff @(posedge clk) begin
    if (rst)            r_cnt <= '0;
    else if (w_in_xfer) r_cnt <= w_is_last ? '0 : r_cnt + CW'(1);
  end

  // Pending-last count and the frame_done pulse after a last entry leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_pend  <= 2'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_last_pend  <= w_last_pend_next;
      r_frame_done <= w_pop_last;
    end
  end

`ifdef RELU_REMASK_CLAMP_EN
  // Sticky flag: any accepted element that needed clamping.
  always_ff @(posedge clk) begin
    if (rst)                       r_clamp_seen <= 1'b0;
    else if (w_in_xfer && w_clamp) r_clamp_seen <= 1'b1;
  end
`endif

endmodule
